// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// baud-tick divisor calculation used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Clock cycles per oversample tick, truncated; callers must keep it >= 1.
    function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divide-by-DIV counter producing a one-cycle tick on its last count.
// The clear input parks the counter at 0 so a new frame starts phase-aligned.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next count: clear wins, otherwise wrap at the last count while enabled.
    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d; otherwise a latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values, independent of block order.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver. RX_LINE is synchronised and oversampled; the start bit is
// confirmed at mid-bit, data bits are sampled one bit period apart from there,
// and the stop bit is checked at its middle before returning to IDLE early so
// a start edge that follows immediately is not missed.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX_LINE,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    input  logic                 READ,
    output logic                 BUSY,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic sync1_q, sync2_q, prev_q;
    logic fall;
    logic tick;

    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 stop_good, stop_bad;

    // Two-flop synchroniser plus one history flop for edge detection; all
    // reset to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= RX_LINE;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q && !sync2_q;

    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != ST_IDLE),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    // Frame sequencing, data sampling and output flag updates.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        s_d     = '0;
                        // A line that is high again at mid-bit was a glitch.
                        state_d = sync2_q ? ST_IDLE : ST_DATA;
                        bit_d   = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == B_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d       = '0;
                        state_d   = ST_IDLE;
                        stop_good = sync2_q;
                        stop_bad  = !sync2_q;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop_good) begin
            data_d = shift_q;
        end
        // A completing byte beats a simultaneous READ; READ then suppresses overrun.
        valid_d = stop_good ? 1'b1 : (READ ? 1'b0 : valid_q);
        ferr_d  = stop_bad  ? 1'b1 : (READ ? 1'b0 : ferr_q);
        ovr_d   = READ ? 1'b0 : (ovr_q | (stop_good & valid_q));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Self-contained UART receiver: the receiving end for the 8N1 byte stream our transmitter produces. Also serves as the replacement receive path for the board top.
- Oversamples RX_LINE and validates the start bit at mid-bit. Shifts 8 data bits LSB-first and checks the stop bit.
- Presents each byte through a VALID/READ handshake, with sticky framing-error and overrun flags.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
(derived) TICK_DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer-truncated, must be >= 1; defaults give 27 (0.5% rate error)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
RX_LINE  in  1  asynchronous serial input; idle high
DATA  out  8  last received byte; holds until the next good frame
VALID  out  1  high while DATA holds an unread byte
READ  in  1  consumer acknowledge; clears VALID and OVERRUN
BUSY  out  1  high while a frame is in progress (any state other than IDLE)
FRAME_ERR  out  1  sticky; set when a stop bit samples 0; cleared by READ or rst
OVERRUN  out  1  sticky; set when a good byte completes while VALID=1; cleared by READ or rst

Behaviour:
- Reset (synchronous, active-high): state=IDLE; DATA=8'h00; VALID=0; BUSY=0; FRAME_ERR=0; OVERRUN=0; tick and bit counters 0; synchronizer flops=1. Reset mid-frame abandons the frame with no flag update.
- Input conditioning: 2-flop synchronizer on RX_LINE (adds 2 cycles of latency). A falling edge is sync=0 while the previous sync=1.
- Tick generator: counter 0..TICK_DIV-1 produces a 1-cycle tick at TICK_DIV-1. It is held at 0 in IDLE and restarts from 0 on the start edge.
- States: IDLE, START, DATA, STOP. A sample counter s counts 0..OVERSAMPLE-1 on ticks.
  - IDLE: on a falling edge -> START, with s=0. A line held low does not re-arm; a fresh 1->0 transition is required.
  - START: at s=OVERSAMPLE/2-1 (mid-bit), if sync=0 -> DATA with bit index 0 and s reset; else (glitch) -> IDLE with no flags.
  - DATA: every OVERSAMPLE ticks, sample at mid-bit and shift right into the shift register (first bit ends in bit 0). After the 8th bit -> STOP.
  - STOP: at mid-bit, if sync=1 (good stop bit): DATA<=shift reg; VALID<=1; OVERRUN<=1 if VALID was already 1. If sync=0: FRAME_ERR<=1; DATA and VALID unchanged. Either way -> IDLE immediately, without waiting for the end of the stop bit, so the receiver resyncs on the next start.
- Latency: VALID rises the cycle after the stop-bit mid-sample tick.
- READ handling:
  - READ clears VALID, FRAME_ERR and OVERRUN on the next edge.
  - READ in the same cycle as a good-byte completion: the new byte wins, VALID stays 1, OVERRUN is not set.
  - READ with VALID=0 has no effect on DATA.
- Overrun: DATA is overwritten with the newest byte; the older byte is lost.
- Back-to-back frames: a start edge accepted in the first cycle after returning to IDLE must be received correctly.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE=0, START=1, DATA=2, STOP=3)
  - DATA_BITS=8
  - tick-divisor constant function, shared with the transmitter
- Sub-module uart_baud_tick: parameterized divisor counter with enable and synchronous clear, outputting a 1-cycle tick. It is reusable by the transmitter.

Test Plan:
(Bench parameters: CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16, so TICK_DIV=1 and 1 bit = 16 clk.)
- Send 0xA5 with a good stop bit, READ held 0 -> VALID=1, DATA=8'hA5, FRAME_ERR=0. VALID rises within 9.5 bit-times (152 clk) of the start edge, plus 2-3 clk pipeline.
- Pulse RX_LINE low for 4 clk, then high -> back to IDLE, VALID=0, BUSY=0, no flags.
- Send 0x3C with stop bit=0 -> FRAME_ERR=1, VALID=0, DATA unchanged (8'h00 after reset). A following READ clears FRAME_ERR.
- Send 0x11 then 0x22 back-to-back with no READ -> DATA=8'h22, VALID=1, OVERRUN=1. READ -> VALID=0, OVERRUN=0.
- Assert READ in the exact cycle the second byte completes -> VALID stays 1, OVERRUN=0, DATA=second byte.
- Assert rst during bit 4 of a frame, then send 0x5A -> all outputs at reset values, then DATA=8'h5A, VALID=1, no flags.
